// File: rtl/cpu_ctrl_fsm_pkg.sv
// cpu_ctrl_fsm_pkg: opcode, ALU op, control bundle and state types shared by the control unit.
package cpu_ctrl_fsm_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ADDI,
    OP_LOAD, OP_STORE, OP_BRZ, OP_BRNZ, OP_JMP, OP_JREG, OP_CALL, OP_SYS
  } opcode_t;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_PASS
  } alu_op_t;
  typedef struct packed {
    logic    branch_rel_nz;
    logic    branch_rel_z;
    logic    branch_abs;
    logic    reg_write_en;
    logic    reg_sel;
    logic    lut_in;
    logic    mem_to_reg;
    logic    alu_src;
    logic    alu_sc_in;
    logic    read_mem;
    logic    write_mem;
    alu_op_t alu_op;
    logic    pc_en;
  } ctrl_t;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_EXEC, S_LOAD_WB, S_HALT} ctrl_state_t;
  localparam ctrl_t CTRL_OFF = '0;
endpackage

// File: rtl/cpu_ctrl_fsm_ctrl_decode.sv
// cpu_ctrl_fsm_ctrl_decode: combinational opcode/fcode to datapath control bundle for the EXEC state.
module cpu_ctrl_fsm_ctrl_decode
  import cpu_ctrl_fsm_pkg::*;
(
  input  opcode_t opcode,
  input  logic    fcode,
  output ctrl_t   ctrl
);
  always_comb begin
    ctrl = CTRL_OFF;
    ctrl.pc_en = 1'b1;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        ctrl.alu_op = alu_op_t'(opcode[2:0]);
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_sc_in = opcode == OP_SUB;
      end
      OP_SHL, OP_SHR: begin
        ctrl.alu_op = alu_op_t'(opcode[2:0]);
        ctrl.reg_write_en = 1'b1;
        ctrl.alu_sc_in = fcode;
      end
      OP_ADDI: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_write_en = 1'b1;
      end
      OP_LOAD: begin
        ctrl.read_mem = 1'b1;
        ctrl.pc_en = 1'b0;
      end
      OP_STORE: ctrl.write_mem = 1'b1;
      OP_BRZ:   ctrl.branch_rel_z = 1'b1;
      OP_BRNZ:  ctrl.branch_rel_nz = 1'b1;
      OP_JMP:   ctrl.branch_abs = 1'b1;
      OP_JREG: begin
        ctrl.branch_abs = 1'b1;
        ctrl.lut_in = 1'b1;
      end
      OP_CALL: begin
        ctrl.reg_sel = 1'b1;
        ctrl.reg_write_en = 1'b1;
        ctrl.branch_abs = 1'b1;
      end
      OP_SYS:   ctrl.pc_en = !fcode;
      default:  ctrl = CTRL_OFF;
    endcase
  end
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control unit sequencing start, execute, two-cycle loads and halt.
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             fcode,
  output logic             CTRL_branch_rel_nz,
  output logic             CTRL_branch_rel_z,
  output logic             CTRL_branch_abs,
  output logic             CTRL_reg_write_en,
  output logic             CTRL_reg_sel,
  output logic             CTRL_lut_in,
  output logic             CTRL_mem_to_reg,
  output logic             CTRL_alu_src,
  output logic             CTRL_alu_sc_in,
  output logic             CTRL_read_mem,
  output logic             CTRL_write_mem,
  output logic [2:0]       CTRL_alu_op,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  ctrl_state_t state, state_nxt;
  ctrl_t dec, ctrl;
  logic retire;
  cpu_ctrl_fsm_ctrl_decode u_decode (
    .opcode(opcode_t'(opcode)),
    .fcode (fcode),
    .ctrl  (dec)
  );
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= S_IDLE;
    else state <= state_nxt;
  end
  // start wins over retirement so a restart always lands on a zero count
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) retired <= '0;
    else if (start) retired <= '0;
    else if (retire && !(&retired)) retired <= retired + CNT_W'(1);
  end
  always_comb begin
    state_nxt = state;
    ctrl = CTRL_OFF;
    retire = 1'b0;
    case (state)
      S_ARM: state_nxt = S_EXEC;
      S_EXEC: begin
        ctrl = dec;
        retire = opcode_t'(opcode) != OP_LOAD;
        state_nxt = opcode_t'(opcode) == OP_LOAD ? S_LOAD_WB :
                    (opcode_t'(opcode) == OP_SYS && fcode) ? S_HALT : S_EXEC;
      end
      S_LOAD_WB: begin
        ctrl.read_mem = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write_en = 1'b1;
        ctrl.pc_en = 1'b1;
        retire = 1'b1;
        state_nxt = S_EXEC;
      end
      default: state_nxt = state;
    endcase
    if (start) state_nxt = S_ARM;
  end
  assign {CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en,
          CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in,
          CTRL_read_mem, CTRL_write_mem, CTRL_alu_op, pc_en} = ctrl;
  assign halted = state == S_HALT;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed stimulus with a rule-level reference model checked every negedge.
module tb_cpu_ctrl_fsm;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic fcode = 1'b0;
  logic b_nz, b_z, b_abs, wr, rsel, lut, m2r, src, sc, rd, wm, pc, hlt;
  logic [2:0] alu;
  logic [15:0] ret;
  logic b_nz4, b_z4, b_abs4, wr4, rsel4, lut4, m2r4, src4, sc4, rd4, wm4, pc4, hlt4;
  logic [2:0] alu4;
  logic [3:0] ret4;
  logic [14:0] dv, dv4;
  int n_cmp = 0, n_fail = 0;
  int ph = 0, cnt = 0, r0;

  cpu_ctrl_fsm #(.CNT_W(16)) dut (
    .CLK(CLK), .reset(reset), .start(start), .opcode(opcode), .fcode(fcode),
    .CTRL_branch_rel_nz(b_nz), .CTRL_branch_rel_z(b_z), .CTRL_branch_abs(b_abs),
    .CTRL_reg_write_en(wr), .CTRL_reg_sel(rsel), .CTRL_lut_in(lut),
    .CTRL_mem_to_reg(m2r), .CTRL_alu_src(src), .CTRL_alu_sc_in(sc),
    .CTRL_read_mem(rd), .CTRL_write_mem(wm), .CTRL_alu_op(alu),
    .pc_en(pc), .halted(hlt), .retired(ret)
  );
  cpu_ctrl_fsm #(.CNT_W(4)) dut4 (
    .CLK(CLK), .reset(reset), .start(start), .opcode(opcode), .fcode(fcode),
    .CTRL_branch_rel_nz(b_nz4), .CTRL_branch_rel_z(b_z4), .CTRL_branch_abs(b_abs4),
    .CTRL_reg_write_en(wr4), .CTRL_reg_sel(rsel4), .CTRL_lut_in(lut4),
    .CTRL_mem_to_reg(m2r4), .CTRL_alu_src(src4), .CTRL_alu_sc_in(sc4),
    .CTRL_read_mem(rd4), .CTRL_write_mem(wm4), .CTRL_alu_op(alu4),
    .pc_en(pc4), .halted(hlt4), .retired(ret4)
  );
  assign dv = {b_nz, b_z, b_abs, wr, rsel, lut, m2r, src, sc, rd, wm, alu, pc};
  assign dv4 = {b_nz4, b_z4, b_abs4, wr4, rsel4, lut4, m2r4, src4, sc4, rd4, wm4, alu4, pc4};

  always #5 CLK = ~CLK;

  // phases: 0 idle, 1 arm, 2 exec, 3 load write-back, 4 halt; cnt is the unsaturated retire count
  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      ph <= 0;
      cnt <= 0;
    end else if (start) begin
      ph <= 1;
      cnt <= 0;
    end else if (ph == 1) ph <= 2;
    else if (ph == 3) begin
      ph <= 2;
      cnt <= cnt + 1;
    end else if (ph == 2) begin
      if (opcode == 4'd8) ph <= 3;
      else begin
        cnt <= cnt + 1;
        if (opcode == 4'd15 && fcode) ph <= 4;
      end
    end
  end

  function automatic logic [14:0] exp_ctrl(int p, int op, bit f);
    logic [2:0] a;
    logic w, s, pe;
    if (p == 3) return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
    if (p != 2) return '0;
    w = op <= 7 || op == 14;
    a = op <= 6 ? 3'(op) : 3'd0;
    s = op == 1 || ((op == 5 || op == 6) && f);
    pe = !(op == 8) && !(op == 15 && f);
    return {op == 11, op == 10, op >= 12 && op <= 14, w, op == 14, op == 13, 1'b0,
            op == 7, s, op == 8, op == 9, a, pe};
  endfunction

  function automatic int sat(int v, int mx);
    return v > mx ? mx : v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #1 reset = 1'b1;
    #10 reset = 1'b0;
    chk("reset_ctrl", 32'(dv), 0);
    chk("reset_retired", 32'(ret), 0);
    chk("reset_halted", 32'(hlt), 0);
    fork
      forever begin
        @(negedge CLK);
        chk("ctrl", 32'(dv), 32'(exp_ctrl(ph, int'(opcode), fcode)));
        chk("ctrl4", 32'(dv4), 32'(exp_ctrl(ph, int'(opcode), fcode)));
        chk("halted", 32'(hlt), 32'(ph == 4));
        chk("retired", 32'(ret), 32'(sat(cnt, 65535)));
        chk("retired4", 32'(ret4), 32'(sat(cnt, 15)));
      end
    join_none
    start = 1'b1;
    opcode = 4'd1;
    repeat (3) step();
    chk("arm_ctrl", 32'(dv), 0);
    start = 1'b0;
    step();
    chk("sub_alu_op", 32'(alu), 1);
    chk("sub_sc_in", 32'(sc), 1);
    chk("sub_wr", 32'(wr), 1);
    chk("sub_pc_en", 32'(pc), 1);
    chk("sub_retired0", 32'(ret), 0);
    step();
    chk("sub_retired1", 32'(ret), 1);
    opcode = 4'd0;
    #1 reset = 1'b1;
    #1;
    chk("async_ctrl", 32'(dv), 0);
    chk("async_pc_en", 32'(pc), 0);
    chk("async_retired", 32'(ret), 0);
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    opcode = 4'd8;
    #1;
    chk("load1_rd", 32'(rd), 1);
    chk("load1_pc_en", 32'(pc), 0);
    r0 = int'(ret);
    step();
    chk("load2_vec", {rd, m2r, wr, pc}, 32'hf);
    step();
    chk("load_retire", 32'(ret), 32'(r0 + 1));
    opcode = 4'd14;
    #1;
    chk("call_vec", {rsel, wr, b_abs, lut}, 32'he);
    opcode = 4'd13;
    #1;
    chk("jreg_vec", {rsel, wr, b_abs, lut}, 32'h3);
    for (int i = 0; i < 15; i++) begin
      opcode = 4'(i);
      fcode = i[0];
      step();
    end
    opcode = 4'd15;
    fcode = 1'b0;
    step();
    chk("nop_halted", 32'(hlt), 0);
    fcode = 1'b1;
    step();
    chk("halt_halted", 32'(hlt), 1);
    chk("halt_ctrl", 32'(dv), 0);
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    opcode = 4'd0;
    fcode = 1'b0;
    step();
    chk("restart_retired", 32'(ret), 0);
    repeat (20) step();
    chk("add20_retired", 32'(ret), 20);
    chk("add20_retired4", 32'(ret4), 15);
    repeat (3) step();
    chk("sat_hold4", 32'(ret4), 15);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control unit driving the CTRL_* inputs of the processor datapath from its opcode/fcode outputs.
- Sequences start, instruction execute, two-cycle loads and halt.
- Adds a PC-advance enable and a retired-instruction counter.
- Sits beside the datapath in the top level; shares CLK and START with it.

Parameters:
- CNT_W, 16, width of retired-instruction counter (saturating).

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE.
- start  input  1  program start pulse/level (same net as datapath START).
- opcode  input  4  instr[8:5] from datapath.
- fcode  input  1  instr[0] from datapath.
- CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en, CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in, CTRL_read_mem, CTRL_write_mem  output  1 each  datapath controls.
- CTRL_alu_op  output  3  ALU operation.
- pc_en  output  1  PC may advance/branch this cycle.
- halted  output  1  HALT state reached.
- retired  output  CNT_W  instructions retired since last start.

Behaviour:
- States: IDLE, ARM, EXEC, LOAD_WB, HALT. State and counter are the only flops; all CTRL/pc_en are combinational from state+opcode+fcode.
- Reset (async): state=IDLE, retired=0. In IDLE/ARM/HALT every CTRL output=0, pc_en=0. halted=1 only in HALT.
- start=1 in any state: next=ARM, retired cleared next edge. ARM holds while start=1; start=0 -> EXEC. The datapath is in its own reset while start is high.
- EXEC decode (opcode -> controls, pc_en=1, retire +1 unless noted):
  - 0 ADD / 1 SUB / 2 AND / 3 OR / 4 XOR: alu_op = opcode, reg_write_en=1. sc_in=1 for SUB, else 0.
  - 5 SHL / 6 SHR: alu_op=5/6, reg_write_en=1, sc_in=fcode.
  - 7 ADDI: alu_op=ADD, alu_src=1, reg_write_en=1.
  - 8 LOAD: read_mem=1, pc_en=0, no retire; next=LOAD_WB.
  - 9 STORE: write_mem=1.
  - 10 BRZ: branch_rel_z=1. 11 BRNZ: branch_rel_nz=1. 12 JMP: branch_abs=1.
  - 13 JREG: branch_abs=1, lut_in=1.
  - 14 CALL: reg_sel=1, reg_write_en=1, branch_abs=1.
  - 15: fcode=1 HALT (pc_en=0, retire +1, next=HALT); fcode=0 NOP (pc_en=1 only).
- LOAD_WB: read_mem=1, mem_to_reg=1, reg_write_en=1, pc_en=1, retire +1; next=EXEC.
- HALT: holds until start or reset.
- retired saturates at 2^CNT_W-1 and does not wrap.
- Unused alu_op value 7 = PASS and is never issued by EXEC decode.
- reset mid-load: outputs drop to 0 immediately (async) and the write-back is abandoned.

Decomposition:
- Package definitions gets:
  - opcode_t enum (16 values above) and alu_op_t enum (ADD..PASS).
  - ctrl_t packed struct of all CTRL bits plus pc_en.
  - ctrl_state_t enum.
- Sub-module ctrl_decode: pure combinational opcode/fcode -> ctrl_t, used in EXEC.
- Top block adds the FSM, the LOAD_WB override, gating and the counter.

Test Plan:
- Reset asserted mid-EXEC with opcode=0 -> all CTRL=0, pc_en=0, retired=0 within same cycle; state IDLE.
- start high 3 cycles then low; opcode=1 -> ARM for 3 cycles, then EXEC with alu_op=1, sc_in=1, reg_write_en=1, pc_en=1; retired=1 after edge.
- opcode=8 -> cycle1 read_mem=1, pc_en=0; cycle2 read_mem=1, mem_to_reg=1, reg_write_en=1, pc_en=1; retired increments by exactly 1.
- opcode=14 -> reg_sel=1, reg_write_en=1, branch_abs=1; opcode=13 -> lut_in=1, branch_abs=1, reg_write_en=0.
- opcode=15, fcode=1 -> halted=1 next cycle, outputs 0; then start pulse -> retired=0 and EXEC resumes. opcode=15, fcode=0 -> NOP, no halt.
- CNT_W=4, 20 ADDs -> retired stops at 15 and stays.
